// File: rtl/cc3_bus_uart_pkg.sv
// rtl/cc3_bus_uart_pkg.sv - register offsets, STATUS/CTRL bit indices and engine states for cc3_bus_uart
package cc3_bus_uart_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_DIVL   = 3'd3;
    localparam logic [2:0] REG_DIVH   = 3'd4;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_TX_NFULL  = 1;
    localparam int ST_TX_IDLE   = 2;
    localparam int ST_RXOVF     = 3;
    localparam int ST_FRAMEERR  = 4;
    localparam int ST_TXOVF     = 5;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/cc3_sync_fifo.sv
// rtl/cc3_sync_fifo.sv - single-clock FIFO with show-ahead head and push-through-when-full
module cc3_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts push+pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/cc3_bus_uart.sv
// rtl/cc3_bus_uart.sv - memory-mapped 8N1 UART responder on the CC3 CPU bus
module cc3_bus_uart
    import cc3_bus_uart_pkg::*;
#(
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = 16'd347
) (
    input  logic       cpu_clk,
    input  logic       cpu_reset_n,
    input  logic       cs_i,
    input  logic [2:0] cpu_addr_i,
    input  logic       cpu_oe_i,
    input  logic       cpu_we_i,
    input  logic [7:0] cpu_data_i,
    output logic [7:0] cpu_data_o,
    input  logic       rxd_i,
    output logic       txd_o,
    output logic       irq_n_o
);

    logic        rd_act, wr_act, rd_prev_q, wr_prev_q, rd_stb, wr_stb;
    logic [1:0]  ctrl_q;
    logic [15:0] div_q;
    logic        rxovf_q, rxovf_d, ferr_q, ferr_d, txovf_q, txovf_d;
    logic        irq_n_q, status_clr;
    logic [7:0]  status;

    logic        tx_push, tx_pop, tx_full, tx_empty, tx_idle;
    logic [7:0]  tx_head;
    uart_state_e tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_sh_q;
    logic        txd_q;

    logic        rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;
    uart_state_e rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_push_q, ferr_set_q;

    assign rd_act     = cs_i & cpu_oe_i;
    assign wr_act     = cs_i & cpu_we_i;
    assign wr_stb     = wr_act & ~wr_prev_q;
    // A simultaneous write suppresses every read side effect.
    assign rd_stb     = rd_act & ~rd_prev_q & ~wr_act;
    assign status_clr = rd_stb & (cpu_addr_i == REG_STATUS);

    assign tx_push = wr_stb & (cpu_addr_i == REG_DATA);
    assign tx_pop  = ~tx_empty & ((tx_state_q == S_IDLE) |
                                  ((tx_state_q == S_STOP) && (tx_cnt_q == '0)));
    assign tx_idle = tx_empty & (tx_state_q == S_IDLE);
    assign rx_pop  = rd_stb & (cpu_addr_i == REG_DATA) & ~rx_empty;

    assign status = {2'b00, txovf_q, ferr_q, rxovf_q, tx_idle, ~tx_full, ~rx_empty};

    // Event set beats a same-cycle clear-on-read.
    always_comb begin
        txovf_d = (tx_push & tx_full & ~tx_pop) | (txovf_q & ~status_clr);
        rxovf_d = (rx_push_q & rx_full & ~rx_pop) | (rxovf_q & ~status_clr);
        ferr_d  = ferr_set_q | (ferr_q & ~status_clr);
    end

    always_comb begin
        cpu_data_o = 8'h00;
        if (rd_act) begin
            case (cpu_addr_i)
                REG_DATA:   cpu_data_o = rx_empty ? 8'h00 : rx_head;
                REG_STATUS: cpu_data_o = status;
                REG_CTRL:   cpu_data_o = {6'b0, ctrl_q};
                REG_DIVL:   cpu_data_o = div_q[7:0];
                REG_DIVH:   cpu_data_o = div_q[15:8];
                default:    cpu_data_o = 8'h00;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            ctrl_q    <= 2'b00;
            div_q     <= DIV_RESET;
            rxovf_q   <= 1'b0;
            ferr_q    <= 1'b0;
            txovf_q   <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            rd_prev_q <= rd_act;
            wr_prev_q <= wr_act;
            rxovf_q   <= rxovf_d;
            ferr_q    <= ferr_d;
            txovf_q   <= txovf_d;
            irq_n_q   <= ~((ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) |
                           (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty));
            if (wr_stb) begin
                case (cpu_addr_i)
                    REG_CTRL: ctrl_q       <= cpu_data_i[1:0];
                    REG_DIVL: div_q[7:0]   <= cpu_data_i;
                    REG_DIVH: div_q[15:8]  <= cpu_data_i;
                    default: ;
                endcase
            end
        end
    end

    cc3_sync_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk(cpu_clk), .rst_n(cpu_reset_n), .push_i(tx_push), .wdata_i(cpu_data_i),
        .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    cc3_sync_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk(cpu_clk), .rst_n(cpu_reset_n), .push_i(rx_push_q), .wdata_i(rx_sh_q),
        .pop_i(rx_pop), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    // Divisor is reloaded at every bit boundary, so DIV writes land cleanly between bits.
    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: if (tx_pop) begin
                    tx_sh_q    <= tx_head;
                    txd_q      <= 1'b0;
                    tx_cnt_q   <= div_q;
                    tx_state_q <= S_START;
                end
                S_START: if (tx_cnt_q == '0) begin
                    txd_q      <= tx_sh_q[0];
                    tx_sh_q    <= tx_sh_q >> 1;
                    tx_cnt_q   <= div_q;
                    tx_bit_q   <= '0;
                    tx_state_q <= S_DATA;
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                S_DATA: if (tx_cnt_q == '0) begin
                    tx_cnt_q <= div_q;
                    if (tx_bit_q == 3'd7) begin
                        txd_q      <= 1'b1;
                        tx_state_q <= S_STOP;
                    end else begin
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 3'd1;
                    end
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                S_STOP: if (tx_cnt_q == '0) begin
                    if (tx_pop) begin
                        tx_sh_q    <= tx_head;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= div_q;
                        tx_state_q <= S_START;
                    end else tx_state_q <= S_IDLE;
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_push_q  <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            rx_s1_q    <= rxd_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_push_q  <= 1'b0;
            ferr_set_q <= 1'b0;
            case (rx_state_q)
                S_IDLE: if (rx_prev_q & ~rx_s2_q) begin
                    rx_cnt_q   <= div_q >> 1;
                    rx_state_q <= S_START;
                end
                S_START: if (rx_cnt_q == '0) begin
                    if (rx_s2_q) rx_state_q <= S_IDLE;
                    else begin
                        rx_cnt_q   <= div_q;
                        rx_bit_q   <= '0;
                        rx_state_q <= S_DATA;
                    end
                end else rx_cnt_q <= rx_cnt_q - 16'd1;
                S_DATA: if (rx_cnt_q == '0) begin
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_q <= div_q;
                    if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                    else rx_bit_q <= rx_bit_q + 3'd1;
                end else rx_cnt_q <= rx_cnt_q - 16'd1;
                S_STOP: if (rx_cnt_q == '0) begin
                    if (rx_s2_q) rx_push_q  <= 1'b1;
                    else         ferr_set_q <= 1'b1;
                    rx_state_q <= S_IDLE;
                end else rx_cnt_q <= rx_cnt_q - 16'd1;
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    assign txd_o   = txd_q;
    assign irq_n_o = irq_n_q;

endmodule

// File: tb/tb_cc3_bus_uart.sv
// tb/tb_cc3_bus_uart.sv - scoreboard bench for cc3_bus_uart with a queue-based UART model
module tb_cc3_bus_uart;

    logic       clk = 1'b0;
    logic       rst_n, cs, oe, we;
    logic [2:0] addr;
    logic [7:0] din, dout;
    logic       rxd, txd, irq_n;
    logic       rxd_drv = 1'b1;
    logic       loop_en = 1'b0;

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rxd_drv;

    cc3_bus_uart dut (
        .cpu_clk(clk), .cpu_reset_n(rst_n), .cs_i(cs), .cpu_addr_i(addr),
        .cpu_oe_i(oe), .cpu_we_i(we), .cpu_data_i(din), .cpu_data_o(dout),
        .rxd_i(rxd), .txd_o(txd), .irq_n_o(irq_n)
    );

    typedef struct {
        string      nm;
        logic [7:0] v;
    } exp_t;

    int         total = 0;
    int         bad = 0;
    int         n_bit = 348;
    bit         tx_mon_en = 1'b0;
    exp_t       rd_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_model[$];
    bit         m_rxovf = 1'b0, m_ferr = 1'b0, m_txovf = 1'b0;
    logic       mprev = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Read-data monitor: compares on the first cycle of each CPU read.
    always @(negedge clk) begin
        logic cur;
        exp_t e;
        cur = cs & oe;
        if (cur && !mprev) begin
            if (rd_q.size() == 0) chk("rd_unexpected", {8'h00, dout}, 16'hFFFF);
            else begin
                e = rd_q.pop_front();
                chk(e.nm, {8'h00, dout}, {8'h00, e.v});
            end
        end
        mprev = cur;
    end

    // Serial TX monitor: decodes frames from txd at the current bit rate.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge txd);
            if (tx_mon_en) begin
                repeat (n_bit / 2) @(negedge clk);
                chk("tx_start", {15'd0, txd}, 16'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (n_bit) @(negedge clk);
                    b[i] = txd;
                end
                repeat (n_bit) @(negedge clk);
                chk("tx_stop", {15'd0, txd}, 16'd1);
                if (tx_q.size() == 0) chk("tx_unexpected", {8'h00, b}, 16'hFFFF);
                else chk("tx_byte", {8'h00, b}, {8'h00, tx_q.pop_front()});
            end
        end
    end

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input string nm, input int hold);
        @(posedge clk); #1;
        rd_q.push_back('{nm, exp});
        cs = 1'b1; oe = 1'b1; addr = a;
        repeat (hold) @(posedge clk);
        #1;
        cs = 1'b0; oe = 1'b0;
    endtask

    task automatic rx_model_push(input logic [7:0] b);
        if (rx_model.size() < 8) rx_model.push_back(b);
        else m_rxovf = 1'b1;
    endtask

    task automatic rd_status(input bit tx_idle, input bit tx_nfull, input string nm);
        logic [7:0] e;
        e = {2'b00, m_txovf, m_ferr, m_rxovf, tx_idle, tx_nfull, rx_model.size() > 0};
        bus_rd(3'd1, e, nm, 1);
        m_txovf = 1'b0; m_ferr = 1'b0; m_rxovf = 1'b0;
    endtask

    task automatic rd_data(input string nm, input int hold);
        logic [7:0] e;
        e = (rx_model.size() > 0) ? rx_model.pop_front() : 8'h00;
        bus_rd(3'd0, e, nm, hold);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        bus_wr(3'd0, b);
        if (tx_mon_en) tx_q.push_back(b);
        if (loop_en) rx_model_push(b);
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_wr(3'd3, d[7:0]);
        bus_wr(3'd4, d[15:8]);
        n_bit = int'(d) + 1;
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rxd_drv = frame[i];
            repeat (n_bit - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        rxd_drv = 1'b1;
        repeat (n_bit) @(posedge clk);
        if (stop_ok) rx_model_push(b);
        else m_ferr = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_txd", {15'd0, txd}, 16'd1);
        chk("rst_irq", {15'd0, irq_n}, 16'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_bit = 348;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cnt;
        logic [15:0] divs[4];
        divs[0] = 16'd3; divs[1] = 16'd5; divs[2] = 16'd7; divs[3] = 16'd9;
        rst_n = 1'b0; cs = 1'b0; oe = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a frame
        bus_wr(3'd0, 8'h55);
        repeat (50) @(posedge clk);
        #1 chk("t1_midframe_txd", {15'd0, txd}, 16'd0);
        do_reset();
        rd_status(1'b1, 1'b1, "t1_status");
        bus_rd(3'd3, 8'h5B, "t1_divl", 1);
        bus_rd(3'd4, 8'h01, "t1_divh", 1);
        bus_rd(3'd2, 8'h00, "t1_ctrl", 1);
        rd_data("t1_data_empty", 1);
        bus_rd(3'd5, 8'h00, "t1_reg5", 1);

        // Single frame with exact start-bit width
        tx_mon_en = 1'b1;
        set_div(16'd3);
        tx_byte(8'hA5);
        cnt = 0;
        while (txd !== 1'b0 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("t2_start_seen", {15'd0, txd}, 16'd0);
        cnt = 0;
        while (txd === 1'b0 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("t2_start_len", 16'(cnt), 16'd4);
        repeat (45) @(posedge clk);
        rd_status(1'b1, 1'b1, "t2_idle");

        // Loopback pair
        loop_en = 1'b1;
        tx_byte(8'h3C);
        tx_byte(8'hC3);
        repeat (100) @(posedge clk);
        rd_status(1'b1, 1'b1, "t3_status");
        for (int i = 0; i < 3; i++) rd_data("t3_data", 1);

        // Randomised loopback bursts at several bit rates
        for (int it = 0; it < 4; it++) begin
            set_div(divs[$urandom_range(0, 3)]);
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) tx_byte(8'($urandom));
            repeat ((k * 10 + 3) * n_bit) @(posedge clk);
            rd_status(1'b1, 1'b1, "rnd_status");
            for (int j = 0; j <= k; j++) rd_data("rnd_data", 1);
        end
        loop_en = 1'b0;
        set_div(16'd3);

        // RX overflow: ten frames into an eight-deep FIFO
        for (int j = 0; j < 10; j++) rx_send(8'($urandom), 1'b1);
        rd_status(1'b1, 1'b1, "rxovf_status");
        for (int j = 0; j < 9; j++) rd_data("rxovf_data", 1);
        rd_status(1'b1, 1'b1, "rxovf_cleared");

        // TX overflow with a stalled shifter
        tx_mon_en = 1'b0;
        set_div(16'hFFFF);
        for (int j = 0; j < 9; j++) bus_wr(3'd0, 8'(j));
        bus_rd(3'd1, 8'h00, "t4_full_no_ovf", 1);
        bus_wr(3'd0, 8'h99);
        bus_rd(3'd1, 8'h20, "t4_txovf", 1);
        bus_rd(3'd1, 8'h00, "t4_txovf_clr", 1);
        do_reset();
        set_div(16'd3);
        tx_mon_en = 1'b1;

        // Frame error, then a one-cycle glitch
        rx_send(8'($urandom), 1'b0);
        repeat (10) @(posedge clk);
        rd_status(1'b1, 1'b1, "t5_ferr");
        rd_status(1'b1, 1'b1, "t5_ferr_clr");
        @(posedge clk); #1 rxd_drv = 1'b0;
        @(posedge clk); #1 rxd_drv = 1'b1;
        repeat (60) @(posedge clk);
        rd_status(1'b1, 1'b1, "t5_glitch");
        rd_data("t5_glitch_data", 1);

        // Interrupts and held read strobe
        bus_wr(3'd2, 8'h01);
        bus_rd(3'd2, 8'h01, "t6_ctrl", 1);
        repeat (3) @(posedge clk);
        #1 chk("t6_irq_idle", {15'd0, irq_n}, 16'd1);
        rx_send(8'($urandom), 1'b1);
        #1 chk("t6_irq_rx", {15'd0, irq_n}, 16'd0);
        rx_send(8'($urandom), 1'b1);
        rd_data("t6_held_read", 5);
        repeat (3) @(posedge clk);
        #1 chk("t6_irq_still", {15'd0, irq_n}, 16'd0);
        rd_data("t6_second", 1);
        repeat (3) @(posedge clk);
        #1 chk("t6_irq_clear", {15'd0, irq_n}, 16'd1);
        rd_status(1'b1, 1'b1, "t6_status");
        bus_wr(3'd2, 8'h02);
        repeat (3) @(posedge clk);
        #1 chk("t6_tx_irq", {15'd0, irq_n}, 16'd0);
        bus_wr(3'd2, 8'h00);
        repeat (3) @(posedge clk);
        #1 chk("t6_irq_off", {15'd0, irq_n}, 16'd1);

        repeat (50) @(posedge clk);
        chk("rd_q_drained", 16'(rd_q.size()), 16'd0);
        chk("tx_q_drained", 16'(tx_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
